// File: rtl/crossy_pkg.sv
// Shared types and constants for the Crossy Robbers game blocks.
package crossy_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    ROUND_END = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int MAX_PLAYERS = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Loadable down-counter advanced by the frame tick; expire pulses on the tick that sees 1.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_q;

  // load wins over tick so a freshly loaded length is never shortened
  always_ff @(posedge clk) begin
    if (!rst_n)                         count_q <= '0;
    else if (load)                      count_q <= load_val;
    else if (tick && count_q > W'(1))   count_q <= count_q - W'(1);
  end

  assign count  = count_q;
  assign expire = tick && (count_q == W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: menu, countdown, play, round end, game over; scores, alive mask, winner.
module game_flow_ctrl
  import crossy_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int NUM_ROUNDS       = 3,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int ROUND_FRAMES     = 3600,
  parameter int END_FRAMES       = 120,
  parameter int SCORE_W          = 8,
  localparam int TIMER_W = $clog2(max3(COUNTDOWN_FRAMES, ROUND_FRAMES, END_FRAMES) + 1),
  localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic                           start_btn,
  input  logic [NUM_PLAYERS-1:0]         player_hit,
  input  logic [NUM_PLAYERS-1:0]         loot_inc,
  output logic [2:0]                     state_o,
  output logic [TIMER_W-1:0]             timer_o,
  output logic [ROUND_W-1:0]             round_o,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
  output logic [NUM_PLAYERS-1:0]         alive_o,
  output logic                           play_en,
  output logic [1:0]                     winner_o,
  output logic                           tie_o
);

  localparam logic [NUM_PLAYERS-1:0] ALL_ALIVE = {NUM_PLAYERS{1'b1}};
  localparam logic [SCORE_W-1:0]     SCORE_MAX = {SCORE_W{1'b1}};

  game_state_t                          state_q, state_d;
  logic [ROUND_W-1:0]                   round_q, round_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  scores_q, scores_d;
  logic [NUM_PLAYERS-1:0]               alive_q, alive_d;
  logic [1:0]                           winner_q, winner_d;
  logic                                 tie_q, tie_d;
  logic                                 play_en_q;
  logic                                 start_q;
  logic                                 start_edge;

  logic                                 tmr_load;
  logic [TIMER_W-1:0]                   tmr_val;
  logic                                 tmr_tick;
  logic [TIMER_W-1:0]                   tmr_count;
  logic                                 tmr_expire;

  logic [1:0]                           win_idx;
  logic [SCORE_W-1:0]                   win_max;
  logic                                 win_tie;

  assign start_edge = start_btn & ~start_q;
  assign tmr_tick   = frame_tick &&
                      (state_q == COUNTDOWN || state_q == PLAY || state_q == ROUND_END);

  frame_timer #(.W(TIMER_W)) u_timer (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  // Linear scan: strict greater-than keeps the lowest index on equal scores
  always_comb begin
    win_idx = '0;
    win_max = scores_q[0];
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_q[i] > win_max) begin
        win_max = scores_q[i];
        win_idx = 2'(i);
      end
    end
    win_tie = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (2'(i) != win_idx && scores_q[i] == win_max) win_tie = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    scores_d = scores_q;
    alive_d  = alive_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      MENU: begin
        if (start_edge) begin
          state_d  = COUNTDOWN;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(COUNTDOWN_FRAMES);
          round_d  = '0;
          scores_d = '0;
          alive_d  = ALL_ALIVE;
        end
      end
      COUNTDOWN: begin
        if (tmr_expire) begin
          state_d  = PLAY;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(ROUND_FRAMES);
        end
      end
      PLAY: begin
        // A hit in the same cycle as loot kills the player and drops the loot
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (player_hit[i])
            alive_d[i] = 1'b0;
          else if (loot_inc[i] && alive_q[i] && scores_q[i] != SCORE_MAX)
            scores_d[i] = scores_q[i] + SCORE_W'(1);
        end
        if (tmr_expire || alive_d == '0) begin
          state_d  = ROUND_END;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(END_FRAMES);
        end
      end
      ROUND_END: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
            state_d  = GAME_OVER;
            tmr_val  = '0;
            winner_d = win_idx;
            tie_d    = win_tie;
          end else begin
            state_d  = COUNTDOWN;
            tmr_val  = TIMER_W'(COUNTDOWN_FRAMES);
            round_d  = round_q + ROUND_W'(1);
            alive_d  = ALL_ALIVE;
          end
        end
      end
      GAME_OVER: begin
        if (start_edge) state_d = MENU;
      end
      default: state_d = MENU;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= MENU;
      round_q   <= '0;
      scores_q  <= '0;
      alive_q   <= ALL_ALIVE;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      play_en_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      scores_q  <= scores_d;
      alive_q   <= alive_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      play_en_q <= (state_d == PLAY);
      start_q   <= start_btn;
    end
  end

  assign state_o  = state_q;
  assign timer_o  = tmr_count;
  assign round_o  = round_q;
  assign scores_o = scores_q;
  assign alive_o  = alive_q;
  assign play_en  = play_en_q;
  assign winner_o = winner_q;
  assign tie_o    = tie_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a queue of expected output values.
module tb_game_flow_ctrl;

  localparam int NP = 2;
  localparam int SW = 4;

  localparam int K_STATE = 0, K_TIMER = 1, K_ROUND = 2, K_SCORES = 3,
                 K_ALIVE = 4, K_PLAY = 5, K_WIN = 6, K_TIE = 7;

  localparam logic [2:0] S_MENU = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2,
                         S_REND = 3'd3, S_GOVER = 3'd4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start_btn = 1'b0;
  logic [NP-1:0] player_hit = '0;
  logic [NP-1:0] loot_inc = '0;
  logic [2:0]    state_o;
  logic [3:0]    timer_o;
  logic [0:0]    round_o;
  logic [NP*SW-1:0] scores_o;
  logic [NP-1:0] alive_o;
  logic          play_en;
  logic [1:0]    winner_o;
  logic          tie_o;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  game_flow_ctrl #(
    .NUM_PLAYERS(NP), .NUM_ROUNDS(2), .COUNTDOWN_FRAMES(3),
    .ROUND_FRAMES(10), .END_FRAMES(2), .SCORE_W(SW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .player_hit(player_hit), .loot_inc(loot_inc), .state_o(state_o),
    .timer_o(timer_o), .round_o(round_o), .scores_o(scores_o),
    .alive_o(alive_o), .play_en(play_en), .winner_o(winner_o), .tie_o(tie_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(input int k);
    case (k)
      K_STATE:  return 32'(state_o);
      K_TIMER:  return 32'(timer_o);
      K_ROUND:  return 32'(round_o);
      K_SCORES: return 32'(scores_o);
      K_ALIVE:  return 32'(alive_o);
      K_PLAY:   return 32'(play_en);
      K_WIN:    return 32'(winner_o);
      default:  return 32'(tie_o);
    endcase
  endfunction

  task automatic expect_v(input int k, input logic [31:0] v, input string tag);
    exp_t e;
    e.kind = k; e.exp = v; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.kind);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge, then clear pulses
  task automatic cyc();
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    player_hit = '0;
    loot_inc   = '0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset
    cyc(); cyc();
    expect_v(K_STATE, S_MENU, "rst_state"); expect_v(K_TIMER, 0, "rst_timer");
    expect_v(K_ROUND, 0, "rst_round");      expect_v(K_SCORES, 0, "rst_scores");
    expect_v(K_ALIVE, 2'b11, "rst_alive");  expect_v(K_PLAY, 0, "rst_play_en");
    expect_v(K_WIN, 0, "rst_winner");       expect_v(K_TIE, 0, "rst_tie");
    drain();
    Reset = 1'b1;
    cyc();

    // game 1: start, countdown, saturation, hit/loot collision, all-dead
    start_btn = 1'b1; cyc(); start_btn = 1'b0;
    expect_v(K_STATE, S_CD, "g1_cd_state"); expect_v(K_TIMER, 3, "g1_cd_timer");
    expect_v(K_PLAY, 0, "g1_cd_play_en"); drain();
    tick(); expect_v(K_TIMER, 2, "g1_cd_t2"); drain();
    tick(); expect_v(K_TIMER, 1, "g1_cd_t1"); expect_v(K_STATE, S_CD, "g1_cd_still"); drain();
    tick();
    expect_v(K_STATE, S_PLAY, "g1_play_state"); expect_v(K_TIMER, 10, "g1_play_timer");
    expect_v(K_PLAY, 1, "g1_play_en"); drain();
    loot_inc = 2'b01; cyc();
    expect_v(K_SCORES, 8'h01, "g1_first_loot"); drain();
    for (int i = 1; i < 20; i++) begin loot_inc = 2'b01; cyc(); end
    expect_v(K_SCORES, 8'h0F, "g1_saturate"); drain();
    player_hit = 2'b10; loot_inc = 2'b10; cyc();
    expect_v(K_ALIVE, 2'b01, "g1_hit_alive"); expect_v(K_SCORES, 8'h0F, "g1_hit_noloot");
    expect_v(K_STATE, S_PLAY, "g1_one_alive"); drain();
    player_hit = 2'b01; cyc();
    expect_v(K_STATE, S_REND, "g1_alldead_state"); expect_v(K_TIMER, 2, "g1_rend_timer");
    expect_v(K_PLAY, 0, "g1_alldead_play_en"); drain();
    ticks(2);
    expect_v(K_STATE, S_CD, "g1_r1_cd"); expect_v(K_ROUND, 1, "g1_r1_round");
    expect_v(K_ALIVE, 2'b11, "g1_r1_alive"); expect_v(K_TIMER, 3, "g1_r1_timer"); drain();
    ticks(3);
    player_hit = 2'b11; cyc();
    expect_v(K_STATE, S_REND, "g1_r1_rend"); drain();
    ticks(2);
    expect_v(K_STATE, S_GOVER, "g1_gover"); expect_v(K_TIMER, 0, "g1_gover_timer");
    expect_v(K_WIN, 0, "g1_winner"); expect_v(K_TIE, 0, "g1_tie"); drain();
    start_btn = 1'b1; cyc(); start_btn = 1'b0;
    expect_v(K_STATE, S_MENU, "g1_to_menu"); expect_v(K_SCORES, 8'h0F, "g1_menu_scores"); drain();
    cyc();

    // game 2: start coincident with tick, timer-ended rounds, 5/5 tie
    start_btn = 1'b1; frame_tick = 1'b1; cyc(); start_btn = 1'b0;
    expect_v(K_STATE, S_CD, "g2_cd"); expect_v(K_TIMER, 3, "g2_tick_on_start");
    expect_v(K_SCORES, 0, "g2_scores_clr"); expect_v(K_ROUND, 0, "g2_round0"); drain();
    ticks(3);
    for (int i = 0; i < 3; i++) begin loot_inc = 2'b11; cyc(); end
    ticks(9);
    expect_v(K_STATE, S_PLAY, "g2_r0_t1_state"); expect_v(K_TIMER, 1, "g2_r0_t1"); drain();
    tick();
    expect_v(K_STATE, S_REND, "g2_r0_expire"); expect_v(K_TIMER, 2, "g2_r0_rend_timer");
    expect_v(K_PLAY, 0, "g2_r0_play_en"); drain();
    loot_inc = 2'b11; player_hit = 2'b11; cyc();
    expect_v(K_SCORES, 8'h33, "g2_rend_ignore_loot"); expect_v(K_ALIVE, 2'b11, "g2_rend_ignore_hit");
    drain();
    ticks(2);
    expect_v(K_STATE, S_CD, "g2_r1_cd"); expect_v(K_ROUND, 1, "g2_r1_round");
    expect_v(K_ALIVE, 2'b11, "g2_r1_alive"); drain();
    ticks(3);
    for (int i = 0; i < 2; i++) begin loot_inc = 2'b11; cyc(); end
    expect_v(K_SCORES, 8'h55, "g2_scores_55"); drain();
    ticks(10);
    expect_v(K_STATE, S_REND, "g2_r1_expire"); drain();
    ticks(2);
    expect_v(K_STATE, S_GOVER, "g2_gover"); expect_v(K_WIN, 0, "g2_winner");
    expect_v(K_TIE, 1, "g2_tie"); expect_v(K_PLAY, 0, "g2_play_en"); drain();

    // game 3: start held through the whole game
    start_btn = 1'b1; cyc();
    expect_v(K_STATE, S_MENU, "g3_menu"); drain();
    cyc();
    expect_v(K_STATE, S_MENU, "g3_held_no_start"); drain();
    start_btn = 1'b0; cyc();
    start_btn = 1'b1; cyc();
    expect_v(K_STATE, S_CD, "g3_cd"); drain();
    ticks(3);
    for (int i = 0; i < 3; i++) begin loot_inc = 2'b10; cyc(); end
    loot_inc = 2'b01; cyc();
    player_hit = 2'b11; cyc();
    ticks(2);
    expect_v(K_STATE, S_CD, "g3_r1_cd"); drain();
    ticks(3 + 10 + 2);
    expect_v(K_STATE, S_GOVER, "g3_gover"); expect_v(K_SCORES, 8'h31, "g3_scores");
    expect_v(K_WIN, 1, "g3_winner"); expect_v(K_TIE, 0, "g3_tie"); drain();
    cyc(); cyc(); cyc();
    expect_v(K_STATE, S_GOVER, "g3_held_stays"); drain();
    start_btn = 1'b0; cyc();
    start_btn = 1'b1; cyc(); start_btn = 1'b0;
    expect_v(K_STATE, S_MENU, "g3_repress_menu"); drain();
    cyc();

    // game 4: reset in the middle of round 1 play
    start_btn = 1'b1; cyc(); start_btn = 1'b0;
    ticks(3);
    player_hit = 2'b11; cyc();
    ticks(2 + 3);
    for (int i = 0; i < 2; i++) begin loot_inc = 2'b01; cyc(); end
    ticks(4);
    player_hit = 2'b10; cyc();
    expect_v(K_STATE, S_PLAY, "g4_play"); expect_v(K_TIMER, 6, "g4_timer6");
    expect_v(K_ROUND, 1, "g4_round1"); expect_v(K_SCORES, 8'h02, "g4_scores");
    expect_v(K_ALIVE, 2'b01, "g4_alive"); drain();
    start_btn = 1'b1; Reset = 1'b0; cyc();
    expect_v(K_STATE, S_MENU, "mr_state"); expect_v(K_TIMER, 0, "mr_timer");
    expect_v(K_ROUND, 0, "mr_round"); expect_v(K_SCORES, 0, "mr_scores");
    expect_v(K_ALIVE, 2'b11, "mr_alive"); expect_v(K_PLAY, 0, "mr_play_en");
    expect_v(K_WIN, 0, "mr_winner"); expect_v(K_TIE, 0, "mr_tie"); drain();
    Reset = 1'b1; cyc();
    expect_v(K_STATE, S_CD, "mr_start_q_cleared"); expect_v(K_TIMER, 3, "mr_cd_timer"); drain();
    start_btn = 1'b0; cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller for Crossy Robbers. It sequences menu, per-round countdown, timed play, round end and game over for a configurable number of players and rounds. It keeps per-player alive flags and saturating loot scores, and selects the winner. It sits between the input/collision logic and the renderer/HUD. All timing advances on the video frame tick.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of robbers, 1..4.
- NUM_ROUNDS, 3: rounds per game, ≥1.
- COUNTDOWN_FRAMES, 180: countdown length in frames, ≥1.
- ROUND_FRAMES, 3600: play length in frames, ≥1.
- END_FRAMES, 120: round-end hold in frames, ≥1.
- SCORE_W, 8: per-player score width.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the Clk rising edge).
- frame_tick  in  1  one-cycle pulse per video frame.
- start_btn  in  1  level input; edge-detected internally.
- player_hit  in  NUM_PLAYERS  one-cycle pulse: player i caught by traffic.
- loot_inc  in  NUM_PLAYERS  one-cycle pulse: player i banks one loot.
- state_o  out  3  current game_state_t.
- timer_o  out  TIMER_W  frames remaining in the current timed state.
- round_o  out  ROUND_W  zero-based round index.
- scores_o  out  NUM_PLAYERS*SCORE_W  packed scores; player 0 occupies the LSBs.
- alive_o  out  NUM_PLAYERS  per-player alive mask.
- play_en  out  1  high only in PLAY.
- winner_o  out  2  winning player index; valid in GAME_OVER.
- tie_o  out  1  high when two or more players share the maximum score; valid in GAME_OVER.

TIMER_W = $clog2(max(COUNTDOWN_FRAMES, ROUND_FRAMES, END_FRAMES)+1). ROUND_W = $clog2(NUM_ROUNDS) with a minimum of 1.

## Operation
- States: MENU, COUNTDOWN, PLAY, ROUND_END, GAME_OVER.
- Start edge: start_edge = start_btn & ~start_q, where start_q is registered every cycle.
- MENU: on start_edge, enter COUNTDOWN with timer = COUNTDOWN_FRAMES, round = 0, scores = 0, alive = all ones.
- Timed states (COUNTDOWN, PLAY, ROUND_END):
  - On frame_tick with timer > 1, decrement the timer.
  - On frame_tick with timer == 1, transition and load the next state's length.
  - Each timed state therefore lasts exactly its parameter count of ticks.
- COUNTDOWN → PLAY, loading ROUND_FRAMES.
- PLAY:
  - loot_inc[i] with alive[i] adds 1 to score[i], saturating at 2^SCORE_W−1.
  - player_hit[i] clears alive[i].
  - If both arrive for the same player in the same cycle, the hit wins and no increment occurs.
  - Inputs outside PLAY are ignored.
- PLAY → ROUND_END, loading END_FRAMES, when either the timer expires or alive becomes all zero (evaluated on the post-hit mask).
  - If both happen in the same cycle, exactly one transition occurs.
- ROUND_END exit:
  - If round == NUM_ROUNDS−1, go to GAME_OVER.
  - Otherwise, round++, alive = all ones, and go to COUNTDOWN with timer = COUNTDOWN_FRAMES.
  - Scores persist across rounds.
- GAME_OVER:
  - winner_o and tie_o are registered on the entry cycle.
  - winner_o is the highest-score player; ties go to the lowest index.
  - timer_o = 0.
  - On start_edge, go to MENU. Scores remain visible until the next start.
- Reset (any state, mid-round included): next edge forces MENU, timer 0, round 0, scores 0, alive all ones, play_en 0, winner 0, tie 0, start_q 0.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- A state change is visible one cycle after the cycle in which its triggering event is sampled.
- A score update is visible the cycle after the loot_inc pulse.
- start_btn held high across MENU→…→GAME_OVER does not retrigger; a new 0→1 edge is required.
- A frame_tick coincident with start_edge in MENU does not decrement the freshly loaded countdown.
- play_en rises the cycle after the final COUNTDOWN tick. It falls the cycle after the expiry tick or the all-dead event.

## Structure
- Shared package crossy_pkg holds:
  - game_state_t enum (logic [2:0]: MENU=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, GAME_OVER=4);
  - MAX_PLAYERS = 4.
- One sub-module, frame_timer:
  - parameter W;
  - inputs: load, load_val, tick;
  - outputs: count, expire (one-cycle pulse on tick when count == 1).
- The FSM, score array, and winner comparator (linear scan) stay in game_flow_ctrl.

## Test plan
Parameters for all scenarios: NUM_PLAYERS=2, NUM_ROUNDS=2, COUNTDOWN_FRAMES=3, ROUND_FRAMES=10, END_FRAMES=2, SCORE_W=4.
- Reset then start_edge: COUNTDOWN with timer_o=3. After exactly 3 ticks, state PLAY with timer_o=10 and play_en=1.
- Saturation: player 0 receives 20 loot_inc pulses in PLAY → score0=15. No pulses for player 1 → score1=0.
- Hit/loot collision and all-dead: hit1 and loot1 in the same cycle → alive_o=2'b01, score1 unchanged. Then hit0 → ROUND_END next cycle with timer_o=2.
- Full game: round 0 ends by timer → COUNTDOWN with round_o=1 and alive_o=2'b11. Round 1 timer expiry → GAME_OVER. With scores 5/5: winner_o=0, tie_o=1.
- Held start: start_btn held high from MENU through the whole game → GAME_OVER is not left. Release then press → MENU.
- Mid-round reset: Reset=0 for one edge during PLAY at timer_o=6 → MENU, scores 0, round 0, play_en 0, alive 2'b11.
